// File: rtl/pwm_bank_pkg.sv
// pwm_bank_pkg
//   Shared constants for the PWM/divider family: default counter width,
//   channel-select width and the per-channel values loaded on reset.
//   No ports; imported by pwm_channel and pwm_bank.
package pwm_bank_pkg;

  localparam int BUS_SIZE_DEF  = 24;
  localparam int CH_SEL_W      = 4;
  localparam int NB_CH_MAX     = 16;
  localparam int NBT_RST_DEF   = 10;
  localparam int NBTON_RST_DEF = 5;

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel
//   One PWM channel: period counter, active and pending period/duty
//   registers, registered output and period-boundary tick.
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   en                run enable; low forces the counter to 0 and the
//                     output to its inactive level
//   wr                write strobe already decoded for this channel
//   nbt_in, nbton_in  new period / active length
//   pwm               registered PWM output
//   tick              one-cycle pulse after the last count of a period
//   pend              a written value is waiting for the period boundary
module pwm_channel
  import pwm_bank_pkg::*;
#(
  parameter int   BUS_SIZE  = BUS_SIZE_DEF,
  parameter int   NBT_RST   = NBT_RST_DEF,
  parameter int   NBTON_RST = NBTON_RST_DEF,
  parameter logic POLARITE  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                wr,
  input  logic [BUS_SIZE-1:0] nbt_in,
  input  logic [BUS_SIZE-1:0] nbton_in,
  output logic                pwm,
  output logic                tick,
  output logic                pend
);

  localparam logic [BUS_SIZE-1:0] ONE = BUS_SIZE'(1);

  logic [BUS_SIZE-1:0] cnt;
  logic [BUS_SIZE-1:0] nbt_a;
  logic [BUS_SIZE-1:0] nbton_a;
  logic [BUS_SIZE-1:0] nbt_p;
  logic [BUS_SIZE-1:0] nbton_p;
  logic [BUS_SIZE-1:0] nbt_eff;
  logic                boundary;

  // A period of 0 runs as a period of 1.
  assign nbt_eff  = (nbt_a == '0) ? ONE : nbt_a;
  assign boundary = (cnt == nbt_eff - ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      nbt_a   <= BUS_SIZE'(NBT_RST);
      nbton_a <= BUS_SIZE'(NBTON_RST);
      nbt_p   <= BUS_SIZE'(NBT_RST);
      nbton_p <= BUS_SIZE'(NBTON_RST);
      pend    <= 1'b0;
      tick    <= 1'b0;
      pwm     <= POLARITE;
    end else begin
      if (wr) begin
        nbt_p   <= nbt_in;
        nbton_p <= nbton_in;
      end
      if (!en) begin
        // Idle channel: no boundary to wait for, so new values go live at once.
        cnt  <= '0;
        tick <= 1'b0;
        pwm  <= POLARITE;
        pend <= 1'b0;
        if (wr) begin
          nbt_a   <= nbt_in;
          nbton_a <= nbton_in;
        end else if (pend) begin
          nbt_a   <= nbt_p;
          nbton_a <= nbton_p;
        end
      end else begin
        pwm  <= (cnt < nbton_a) ? ~POLARITE : POLARITE;
        tick <= boundary;
        if (boundary) begin
          cnt  <= '0;
          pend <= 1'b0;
          // A write landing on the boundary itself bypasses the pending stage.
          if (wr) begin
            nbt_a   <= nbt_in;
            nbton_a <= nbton_in;
          end else if (pend) begin
            nbt_a   <= nbt_p;
            nbton_a <= nbton_p;
          end
        end else begin
          cnt <= cnt + ONE;
          if (wr) pend <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pwm_bank.sv
// pwm_bank
//   Bank of NB_CH independent PWM channels sharing one write port.
// Ports
//   clkIn              clock, rising edge
//   rstIn              asynchronous active-high reset
//   en[NB_CH]          per-channel run enable
//   wr, ch_sel         write strobe and target channel (ch_sel >= NB_CH ignored)
//   nbt_in, nbton_in   period / active length carried by wr
//   pwmOut[NB_CH]      registered PWM outputs
//   tick[NB_CH]        per-channel period-boundary pulses
//   pend[NB_CH]        per-channel write-pending flags
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int   BUS_SIZE  = BUS_SIZE_DEF,
  parameter int   NB_CH     = 4,
  parameter int   NBT_RST   = NBT_RST_DEF,
  parameter int   NBTON_RST = NBTON_RST_DEF,
  parameter logic POLARITE  = 1'b0
) (
  input  logic                clkIn,
  input  logic                rstIn,
  input  logic [NB_CH-1:0]    en,
  input  logic                wr,
  input  logic [CH_SEL_W-1:0] ch_sel,
  input  logic [BUS_SIZE-1:0] nbt_in,
  input  logic [BUS_SIZE-1:0] nbton_in,
  output logic [NB_CH-1:0]    pwmOut,
  output logic [NB_CH-1:0]    tick,
  output logic [NB_CH-1:0]    pend
);

  for (genvar i = 0; i < NB_CH; i++) begin : g_ch
    logic wr_ch;

    // Selects beyond NB_CH never match any generated channel.
    assign wr_ch = wr && (ch_sel == CH_SEL_W'(i));

    pwm_channel #(
      .BUS_SIZE  (BUS_SIZE),
      .NBT_RST   (NBT_RST),
      .NBTON_RST (NBTON_RST),
      .POLARITE  (POLARITE)
    ) u_ch (
      .clk      (clkIn),
      .rst      (rstIn),
      .en       (en[i]),
      .wr       (wr_ch),
      .nbt_in   (nbt_in),
      .nbton_in (nbton_in),
      .pwm      (pwmOut[i]),
      .tick     (tick[i]),
      .pend     (pend[i])
    );
  end

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank
//   Scoreboard bench for pwm_bank: the stimulus process steps a phase-based
//   reference model and queues the outputs expected after each clock edge;
//   a monitor pops and compares one entry per clock.
module tb_pwm_bank;

  localparam int   NB   = 4;
  localparam int   BUS  = 24;
  localparam logic POL  = 1'b0;
  localparam logic ACT  = ~POL;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NB-1:0]   en  = '0;
  logic            wr  = 1'b0;
  logic [3:0]      ch_sel = '0;
  logic [BUS-1:0]  nbt_in = '0;
  logic [BUS-1:0]  nbton_in = '0;
  logic [NB-1:0]   pwm_out;
  logic [NB-1:0]   tick;
  logic [NB-1:0]   pend;

  always #5 clk = ~clk;

  pwm_bank #(.BUS_SIZE(BUS), .NB_CH(NB), .NBT_RST(10), .NBTON_RST(5), .POLARITE(POL)) dut (
    .clkIn(clk), .rstIn(rst), .en(en), .wr(wr), .ch_sel(ch_sel),
    .nbt_in(nbt_in), .nbton_in(nbton_in),
    .pwmOut(pwm_out), .tick(tick), .pend(pend)
  );

  typedef struct {
    logic [NB-1:0] pwm;
    logic [NB-1:0] tick;
    logic [NB-1:0] pend;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: phase within the current period plus live and queued settings.
  int   phase [NB];
  int   per   [NB];
  int   dty   [NB];
  int   per_q [NB];
  int   dty_q [NB];
  bit   queued[NB];

  function automatic int period_of(input int p);
    return (p < 1) ? 1 : p;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) begin
      phase[i] = 0; per[i] = 10; dty[i] = 5;
      per_q[i] = 10; dty_q[i] = 5; queued[i] = 0;
    end
  endfunction

  task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs, wait a clock.
  task automatic step(input logic [NB-1:0] en_v, input logic wr_v, input logic [3:0] sel_v,
                      input int nb, input int on);
    exp_t e;
    en = en_v; wr = wr_v; ch_sel = sel_v;
    nbt_in = BUS'(nb); nbton_in = BUS'(on);
    for (int i = 0; i < NB; i++) begin
      bit hit;
      bit last;
      hit = wr_v && (int'(sel_v) == i);
      if (rst) begin
        e.pwm[i] = POL; e.tick[i] = 1'b0; e.pend[i] = 1'b0;
      end else if (!en_v[i]) begin
        e.pwm[i] = POL; e.tick[i] = 1'b0;
        if (hit) begin
          per_q[i] = nb; dty_q[i] = on;
        end
        if (hit || queued[i]) begin
          per[i] = per_q[i]; dty[i] = dty_q[i];
        end
        queued[i] = 0; phase[i] = 0;
        e.pend[i] = 1'b0;
      end else begin
        e.pwm[i]  = (phase[i] < dty[i]) ? ACT : POL;
        last      = (phase[i] == period_of(per[i]) - 1);
        e.tick[i] = last;
        if (hit) begin
          per_q[i] = nb; dty_q[i] = on; queued[i] = 1;
        end
        if (last) begin
          if (queued[i]) begin
            per[i] = per_q[i]; dty[i] = dty_q[i];
          end
          queued[i] = 0; phase[i] = 0;
        end else begin
          phase[i] = phase[i] + 1;
        end
        e.pend[i] = queued[i];
      end
    end
    if (rst) model_reset();
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(en, 1'b0, 4'd0, 0, 0);
  endtask

  // Monitor: every clock presents one output set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check("pwmOut", pwm_out, e.pwm);
        check("tick",   tick,    e.tick);
        check("pend",   pend,    e.pend);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(negedge clk);
    check("reset_pwm",  pwm_out, {NB{POL}});
    check("reset_tick", tick,    '0);
    check("reset_pend", pend,    '0);
    step('0, 1'b0, 4'd0, 0, 0);
    rst = 1'b0;

    // Defaults 10/5 on every channel.
    idle(2);
    step('1, 1'b0, 4'd0, 0, 0);
    idle(24);

    // Mid-period write on ch0.
    for (int k = 0; k < 20 && phase[0] != 3; k++) idle(1);
    step('1, 1'b1, 4'd0, 4, 1);
    idle(20);

    // Write on ch1's boundary cycle: bypass, pend stays 0.
    for (int k = 0; k < 20 && phase[1] != period_of(per[1]) - 1; k++) idle(1);
    step('1, 1'b1, 4'd1, 6, 6);
    idle(14);

    // Zero period/duty on ch2, then duty 1.
    step('1, 1'b1, 4'd2, 0, 0);
    idle(14);
    step('1, 1'b1, 4'd2, 0, 1);
    idle(6);

    // Ignored select.
    step('1, 1'b1, 4'd9, 3, 1);
    idle(3);

    // Disable ch3 at cnt=2, write 8/2 while idle, re-enable.
    for (int k = 0; k < 20 && phase[3] != 2; k++) idle(1);
    step(4'b0111, 1'b0, 4'd0, 0, 0);
    step(4'b0111, 1'b1, 4'd3, 8, 2);
    idle(3);
    step('1, 1'b0, 4'd0, 0, 0);
    idle(18);

    // Async reset between edges with a pending write on ch0.
    for (int k = 0; k < 20 && !(phase[0] == 0 && period_of(per[0]) > 1); k++) idle(1);
    step('1, 1'b1, 4'd0, 7, 3);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pwm",  pwm_out, {NB{POL}});
    check("async_rst_tick", tick,    '0);
    check("async_rst_pend", pend,    '0);
    step('1, 1'b0, 4'd0, 0, 0);
    rst = 1'b0;
    idle(25);

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      logic [NB-1:0] ev;
      for (int i = 0; i < NB; i++) ev[i] = ($urandom_range(0, 7) != 0);
      step(ev, ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
           int'($urandom_range(0, 9)), int'($urandom_range(0, 10)));
    end
    idle(2);

    for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
